mc_control_fsm: RTL and testbench

- Control sequencer for the multicycle RV32I core.
- Steps a 5-state FSM (IF, ID, EX, MEM, WB) and decodes the instruction word.
- Drives every datapath enable and mux select: PC load and source, ALU operand and op, memory read/write, register write-back.
- Sits between the instruction ROM output and the core datapath; exports current_state for bench monitors.

---
 rtl/mc_ctrl_pkg.sv | 29 ++
 rtl/mc_alu_decode.sv | 57 +++++
 rtl/mc_control_fsm.sv | 146 ++++++++++++++
 tb/tb_mc_control_fsm.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control sequencer:
// FSM state codes, base opcodes and ALU operation codes.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF  = 3'b000,
      S_ID  = 3'b001,
      S_EX  = 3'b010,
      S_MEM = 3'b011,
      S_WB  = 3'b100
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU-operation decode from the registered instruction fields.
// Unsupported opcode/funct combinations raise illegal and force ALU_AND (0000).
module mc_alu_decode
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   input  logic       funct7_rsvd,
   output logic [3:0] alu_ctrl,
   output logic       illegal
);

   logic [3:0] alu_raw;
   logic       bad;

   always_comb begin
      alu_raw = ALU_ADD;
      bad     = 1'b0;
      unique case (opcode)
         OP_RTYPE: begin
            // Only ADD/SUB and SRL/SRA may use funct7 = 0100000.
            unique case (funct3)
               3'b000: begin alu_raw = funct7_b5 ? ALU_SUB : ALU_ADD; bad = funct7_rsvd; end
               3'b001: begin alu_raw = ALU_SLL; bad = funct7_b5 | funct7_rsvd; end
               3'b010: begin alu_raw = ALU_SLT; bad = funct7_b5 | funct7_rsvd; end
               3'b100: begin alu_raw = ALU_XOR; bad = funct7_b5 | funct7_rsvd; end
               3'b101: begin alu_raw = funct7_b5 ? ALU_SRA : ALU_SRL; bad = funct7_rsvd; end
               3'b110: begin alu_raw = ALU_OR;  bad = funct7_b5 | funct7_rsvd; end
               3'b111: begin alu_raw = ALU_AND; bad = funct7_b5 | funct7_rsvd; end
               default: bad = 1'b1;
            endcase
         end
         OP_ITYPE: begin
            // Upper immediate bits only carry funct7 for the shift forms.
            unique case (funct3)
               3'b000: alu_raw = ALU_ADD;
               3'b010: alu_raw = ALU_SLT;
               3'b100: alu_raw = ALU_XOR;
               3'b110: alu_raw = ALU_OR;
               3'b111: alu_raw = ALU_AND;
               3'b001: begin alu_raw = ALU_SLL; bad = funct7_b5 | funct7_rsvd; end
               3'b101: begin alu_raw = funct7_b5 ? ALU_SRA : ALU_SRL; bad = funct7_rsvd; end
               default: bad = 1'b1;
            endcase
         end
         OP_LOAD:   begin alu_raw = ALU_ADD; bad = (funct3 != 3'b010); end
         OP_STORE:  begin alu_raw = ALU_ADD; bad = (funct3 != 3'b010); end
         OP_BRANCH: begin alu_raw = ALU_SUB; bad = (funct3 != 3'b000); end
         default:   bad = 1'b1;
      endcase
   end

   assign illegal  = bad;
   assign alu_ctrl = bad ? ALU_AND : alu_raw;

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control sequencer: IF/ID/EX/MEM/WB FSM with Moore outputs.
// Optional performance counters are built when PERF_CNT_EN is defined.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W      = 32,
   parameter int ALU_CTRL_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic [31:0]           instr,
   input  logic                  zero,
   output logic [2:0]            current_state,
   output logic                  loadPC,
   output logic                  PCSrc,
   output logic                  ALUSrc,
   output logic [ALU_CTRL_W-1:0] ALUCtrl,
   output logic                  MemRead,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic                  MemToReg,
   output logic                  illegal_instr,
   output logic                  instr_retired
`ifdef PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      cycle_count,
   output logic [CNT_W-1:0]      retired_count
`endif
);

   if (CNT_W < 1 || ALU_CTRL_W < 4) begin : g_bad_param
      $error("mc_control_fsm: CNT_W must be >= 1 and ALU_CTRL_W >= 4");
   end

   state_t     state, state_nxt;
   logic [6:0] opc_q;
   logic [2:0] f3_q;
   logic       f7b5_q;
   logic       f7rsvd_q;
   logic       branch_taken;
   logic [3:0] dec_alu;
   logic       dec_ill;
   logic       is_rtype, is_itype, is_load, is_store, is_branch;

   always_ff @(posedge clk) begin
      if (rst) state <= S_IF;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (!stall) begin
         unique case (state)
            S_IF:    state_nxt = S_ID;
            S_ID:    state_nxt = S_EX;
            S_EX:    state_nxt = S_MEM;
            S_MEM:   state_nxt = S_WB;
            default: state_nxt = S_IF;
         endcase
      end
   end

   // Decode fields are captured once; the datapath holds instr stable anyway.
   always_ff @(posedge clk) begin
      if (rst) begin
         opc_q    <= '0;
         f3_q     <= '0;
         f7b5_q   <= 1'b0;
         f7rsvd_q <= 1'b0;
      end else if (!stall && state == S_ID) begin
         opc_q    <= instr[6:0];
         f3_q     <= instr[14:12];
         f7b5_q   <= instr[30];
         f7rsvd_q <= instr[31] | (|instr[29:25]);
      end
   end

   mc_alu_decode u_alu_decode (
      .opcode      (opc_q),
      .funct3      (f3_q),
      .funct7_b5   (f7b5_q),
      .funct7_rsvd (f7rsvd_q),
      .alu_ctrl    (dec_alu),
      .illegal     (dec_ill)
   );

   assign is_rtype  = (opc_q == OP_RTYPE);
   assign is_itype  = (opc_q == OP_ITYPE);
   assign is_load   = (opc_q == OP_LOAD);
   assign is_store  = (opc_q == OP_STORE);
   assign is_branch = (opc_q == OP_BRANCH);

   always_ff @(posedge clk) begin
      if (rst) begin
         branch_taken <= 1'b0;
      end else if (!stall) begin
         if (state == S_IF)      branch_taken <= 1'b0;
         else if (state == S_EX) branch_taken <= is_branch & ~dec_ill & zero;
      end
   end

   always_comb begin
      loadPC        = 1'b0;
      PCSrc         = 1'b0;
      ALUSrc        = 1'b0;
      ALUCtrl       = '0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      RegWrite      = 1'b0;
      MemToReg      = 1'b0;
      illegal_instr = 1'b0;
      instr_retired = 1'b0;
      if (state == S_EX || state == S_MEM || state == S_WB) begin
         ALUSrc        = is_itype | is_load | is_store;
         ALUCtrl       = ALU_CTRL_W'(dec_alu);
         illegal_instr = dec_ill;
      end
      if (state == S_MEM) begin
         MemRead  = is_load  & ~dec_ill;
         MemWrite = is_store & ~dec_ill;
      end
      if (state == S_WB) begin
         RegWrite      = (is_rtype | is_itype | is_load) & ~dec_ill;
         MemToReg      = is_load & ~dec_ill;
         loadPC        = 1'b1;
         PCSrc         = branch_taken;
         instr_retired = 1'b1;
      end
   end

   assign current_state = state;

`ifdef PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count   <= '0;
         retired_count <= '0;
      end else begin
         cycle_count   <= cycle_count + 1'b1;
         retired_count <= retired_count + CNT_W'(instr_retired);
      end
   end
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: per-instruction expected output vectors
// are queued as stimulus is driven and popped as each state is observed.
module tb_mc_control_fsm;

   localparam int CNT_W = 32;

   typedef struct packed {
      logic [2:0] st;
      logic       lpc;
      logic       pcs;
      logic       src;
      logic [3:0] alu;
      logic       mr;
      logic       mw;
      logic       rw;
      logic       m2r;
      logic       ill;
      logic       ret;
   } exp_t;

   typedef struct packed {
      logic [3:0] alu;
      logic       src;
      logic       ld;
      logic       st;
      logic       rw;
      logic       pcs;
      logic       ill;
   } kind_t;

   logic        clk = 1'b0;
   logic        rst, stall, zero;
   logic [31:0] instr;
   logic [2:0]  current_state;
   logic        loadPC, PCSrc, ALUSrc, MemRead, MemWrite, RegWrite, MemToReg;
   logic        illegal_instr, instr_retired;
   logic [3:0]  ALUCtrl;
`ifdef PERF_CNT_EN
   logic [CNT_W-1:0] cycle_count, retired_count;
`endif

   int errors = 0;
   int checks = 0;
   exp_t exp_q[$];

   mc_control_fsm #(.CNT_W(CNT_W), .ALU_CTRL_W(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .instr         (instr),
      .zero          (zero),
      .current_state (current_state),
      .loadPC        (loadPC),
      .PCSrc         (PCSrc),
      .ALUSrc        (ALUSrc),
      .ALUCtrl       (ALUCtrl),
      .MemRead       (MemRead),
      .MemWrite      (MemWrite),
      .RegWrite      (RegWrite),
      .MemToReg      (MemToReg),
      .illegal_instr (illegal_instr),
      .instr_retired (instr_retired)
`ifdef PERF_CNT_EN
      ,
      .cycle_count   (cycle_count),
      .retired_count (retired_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic exp_t vec(input int s, input kind_t k);
      exp_t e;
      e = '0;
      e.st = 3'(s);
      if (s >= 2) begin
         e.alu = k.alu;
         e.src = k.src;
         e.ill = k.ill;
      end
      if (s == 3) begin
         e.mr = k.ld;
         e.mw = k.st;
      end
      if (s == 4) begin
         e.rw  = k.rw;
         e.m2r = k.ld;
         e.lpc = 1'b1;
         e.pcs = k.pcs;
         e.ret = 1'b1;
      end
      return e;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o.st  = current_state;
      o.lpc = loadPC;
      o.pcs = PCSrc;
      o.src = ALUSrc;
      o.alu = ALUCtrl;
      o.mr  = MemRead;
      o.mw  = MemWrite;
      o.rw  = RegWrite;
      o.m2r = MemToReg;
      o.ill = illegal_instr;
      o.ret = instr_retired;
      return o;
   endfunction

   task automatic check(input string tag);
      exp_t e, o;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, observe());
         return;
      end
      e = exp_q.pop_front();
      o = observe();
      assert (o === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   // Runs one instruction from IF; optional stall or reset at a given state.
   task automatic run_instr(input logic [31:0] iw, input logic z, input kind_t k,
                            input string tag, input int stall_at, input int nstall,
                            input int rst_at);
      instr = iw;
      zero  = z;
      for (int s = 0; s < 5; s++) begin
         if (s > 0) begin
            @(posedge clk);
            #1;
         end
         exp_q.push_back(vec(s, k));
         check($sformatf("%s_s%0d", tag, s));
         if (s == stall_at) begin
            stall = 1'b1;
            for (int n = 0; n < nstall; n++) begin
               @(posedge clk);
               #1;
               exp_q.push_back(vec(s, k));
               check($sformatf("%s_stall%0d", tag, n));
            end
            stall = 1'b0;
         end
         if (s == rst_at) begin
            rst   = 1'b1;
            stall = 1'b1;
            @(posedge clk);
            #1;
            exp_q.push_back('0);
            check($sformatf("%s_rst", tag));
`ifdef PERF_CNT_EN
            checks++;
            assert (cycle_count === '0 && retired_count === '0) else begin
               errors++;
               $error("FAIL %s_cnt: observed %0d/%0d expected 0/0", tag, cycle_count, retired_count);
            end
`endif
            rst   = 1'b0;
            stall = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
   endtask

   //                        alu      src ld  st  rw  pcs ill
   localparam kind_t K_ADD  = '{4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam kind_t K_SUB  = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam kind_t K_XOR  = '{4'b1101, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam kind_t K_ANDI = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam kind_t K_SRAI = '{4'b1010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam kind_t K_LW   = '{4'b0010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam kind_t K_SW   = '{4'b0010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam kind_t K_BEQT = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam kind_t K_BEQN = '{4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam kind_t K_ILLX = '{4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam kind_t K_ILLI = '{4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   initial begin
      rst   = 1'b1;
      stall = 1'b0;
      zero  = 1'b0;
      instr = 32'h0000_0000;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back('0);
      check("reset");
      rst = 1'b0;

      run_instr(32'h002081B3, 1'b0, K_ADD,  "add",      -1, 0, -1);
      run_instr(32'h0080A283, 1'b0, K_LW,   "lw",       -1, 0, -1);
      run_instr(32'h0050A623, 1'b0, K_SW,   "sw",       -1, 0, -1);
      run_instr(32'h00208463, 1'b1, K_BEQT, "beq_t",    -1, 0, -1);
      run_instr(32'h00208463, 1'b0, K_BEQN, "beq_n",    -1, 0, -1);
      run_instr(32'h0000007F, 1'b0, K_ILLX, "ill_op",   -1, 0, -1);
      run_instr(32'h4220D193, 1'b0, K_ILLI, "ill_srai", -1, 0, -1);
      run_instr(32'h40209193, 1'b0, K_ILLI, "ill_slli", -1, 0, -1);
      run_instr(32'h4020D193, 1'b0, K_SRAI, "srai",     -1, 0, -1);
      run_instr(32'h402081B3, 1'b0, K_SUB,  "sub",      -1, 0, -1);
      run_instr(32'h0020C1B3, 1'b0, K_XOR,  "xor",      -1, 0, -1);
      run_instr(32'h0050F193, 1'b1, K_ANDI, "andi",     -1, 0, -1);
      run_instr(32'h0050A623, 1'b0, K_SW,   "sw_stall",  3, 3, -1);
      run_instr(32'h0050A623, 1'b0, K_SW,   "sw_rst",   -1, 0,  3);
      run_instr(32'h002081B3, 1'b0, K_ADD,  "add_post", -1, 0, -1);

      if (exp_q.size() != 0) begin
         errors++;
         $error("FAIL leftover: observed %0d queued entries expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
